vgroup_sequencer: RTL

//  Registered micro-op sequencer that sits directly upstream of the LMUL grouping selection logic.
//  It accepts one vector instruction (raA, raB, rdest, encoded LMUL) per valid/ready handshake.
//  It emits LMUL consecutive micro-ops, one per accepted output beat, with every register index offset by the beat number.
//  It drives the stall that holds the IF1/IF2 fetch stages while a register group is still being expanded.

---
 rtl/vgroup_sequencer_pkg.sv | 27 ++
 rtl/vgroup_sequencer_if.sv | 42 ++++
 rtl/vgroup_offset_add.sv | 14 +
 rtl/vgroup_sequencer.sv | 109 ++++++++++
 4 files changed

// File: rtl/vgroup_sequencer_pkg.sv
// Shared types for the vector register-group sequencer: LMUL encodings, FSM states, LMUL decode.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package vec_pkg;

  localparam logic [2:0] LMUL_1 = 3'b000;
  localparam logic [2:0] LMUL_2 = 3'b001;
  localparam logic [2:0] LMUL_4 = 3'b010;
  localparam logic [2:0] LMUL_8 = 3'b011;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } vgseq_state_t;

  // Group size for an LMUL encoding; any 1xx code maps to max_lmul.
  function automatic logic [3:0] lmul_decode(input logic [2:0] enc, input logic [3:0] max_lmul);
    case (enc)
      LMUL_1:  lmul_decode = 4'd1;
      LMUL_2:  lmul_decode = 4'd2;
      LMUL_4:  lmul_decode = 4'd4;
      LMUL_8:  lmul_decode = 4'd8;
      default: lmul_decode = max_lmul;
    endcase
  endfunction

endpackage

// File: rtl/vgroup_sequencer_if.sv
// Instruction-in / micro-op-out bus of the group sequencer (out_illegal only with VGSEQ_ALIGN_CHECK_EN).
// Latency: none (wiring only).
// Backpressure: in_ready/out_ready valid-ready handshakes on each side.
interface vgroup_sequencer_if #(
  parameter int REG_AW = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [REG_AW-1:0] in_raA;
  logic [REG_AW-1:0] in_raB;
  logic [REG_AW-1:0] in_rdest;
  logic [2:0]        in_lmul;
  logic              out_valid;
  logic              out_ready;
  logic [REG_AW-1:0] out_raA;
  logic [REG_AW-1:0] out_raB;
  logic [REG_AW-1:0] out_rdest;
  logic [2:0]        out_idx;
  logic              out_last;
`ifdef VGSEQ_ALIGN_CHECK_EN
  logic              out_illegal;
`endif

  // Instruction source plus micro-op sink (e.g. decode front end / bench).
  modport master (
    output in_valid, in_raA, in_raB, in_rdest, in_lmul, out_ready,
    input  in_ready, out_valid, out_raA, out_raB, out_rdest, out_idx, out_last
`ifdef VGSEQ_ALIGN_CHECK_EN
    , out_illegal
`endif
  );

  // The sequencer itself.
  modport slave (
    input  in_valid, in_raA, in_raB, in_rdest, in_lmul, out_ready,
    output in_ready, out_valid, out_raA, out_raB, out_rdest, out_idx, out_last
`ifdef VGSEQ_ALIGN_CHECK_EN
    , out_illegal
`endif
  );

endinterface

// File: rtl/vgroup_offset_add.sv
// Register index plus beat offset, wrapping modulo 2**REG_AW.
// Latency: combinational.
// Backpressure: not applicable.
module vgroup_offset_add #(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] base_i,
  input  logic [2:0]        idx_i,
  output logic [REG_AW-1:0] sum_o
);

  assign sum_o = base_i + REG_AW'(idx_i);

endmodule

// File: rtl/vgroup_sequencer.sv
// Expands one vector instruction into LMUL micro-ops with offset register indices; stalls IF1/IF2 meanwhile.
// Latency: instruction accepted at edge N shows beat 0 after edge N; one beat per cycle while out_ready=1.
// Backpressure: out_* held while out_ready=0; in_ready only in IDLE or on an accepted last beat. VGSEQ_ALIGN_CHECK_EN adds out_illegal.
module vgroup_sequencer
  import vec_pkg::*;
#(
  parameter int MAX_LMUL = 8,
  parameter int REG_AW   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  vgroup_sequencer_if.slave bus,
  output logic              fetch_stall
);

  vgseq_state_t      state_q, state_d;
  logic [2:0]        idx_q, idx_d;
  logic [2:0]        last_idx_q, last_idx_d;
  logic [REG_AW-1:0] raa_q, rab_q, rd_q;
  logic              illegal_q, illegal_d;

  logic              issuing, last_beat, in_ready_w, accept, out_fire;
  logic [3:0]        dec_lmul;

  assign issuing    = (state_q == ISSUE);
  assign last_beat  = issuing && (idx_q == last_idx_q);
  // flush blocks acceptance so that nothing is taken on the cycle being flushed.
  assign in_ready_w = !flush && (!issuing || (last_beat && bus.out_ready));
  assign accept     = bus.in_valid && in_ready_w;
  assign out_fire   = issuing && bus.out_ready;
  assign dec_lmul   = lmul_decode(bus.in_lmul, 4'(MAX_LMUL));

  // Decode the incoming instruction: final beat index and (optionally) the illegal flag.
  always_comb begin
    last_idx_d = 3'(dec_lmul - 4'd1);
    illegal_d  = 1'b0;
`ifdef VGSEQ_ALIGN_CHECK_EN
    // Group size is a power of two, so base mod LMUL is a mask of the low bits.
    illegal_d = bus.in_lmul[2]
             || (|(bus.in_raA   & REG_AW'(dec_lmul - 4'd1)))
             || (|(bus.in_raB   & REG_AW'(dec_lmul - 4'd1)))
             || (|(bus.in_rdest & REG_AW'(dec_lmul - 4'd1)));
    if (illegal_d) last_idx_d = 3'd0;
`endif
  end

  // Next state and beat counter; flush wins over both handshakes.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (flush) begin
      state_d = IDLE;
      idx_d   = 3'd0;
    end else if (accept) begin
      state_d = ISSUE;
      idx_d   = 3'd0;
    end else if (out_fire) begin
      if (last_beat) state_d = IDLE;
      else           idx_d   = idx_q + 3'd1;
    end
  end

  // FSM state and beat index registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Instruction fields captured on acceptance and held for the whole group.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      raa_q      <= '0;
      rab_q      <= '0;
      rd_q       <= '0;
      last_idx_q <= 3'd0;
      illegal_q  <= 1'b0;
    end else if (accept) begin
      raa_q      <= bus.in_raA;
      rab_q      <= bus.in_raB;
      rd_q       <= bus.in_rdest;
      last_idx_q <= last_idx_d;
      illegal_q  <= illegal_d;
    end
  end

  vgroup_offset_add #(.REG_AW(REG_AW)) u_add_raa (.base_i(raa_q), .idx_i(idx_q), .sum_o(bus.out_raA));
  vgroup_offset_add #(.REG_AW(REG_AW)) u_add_rab (.base_i(rab_q), .idx_i(idx_q), .sum_o(bus.out_raB));
  vgroup_offset_add #(.REG_AW(REG_AW)) u_add_rd  (.base_i(rd_q),  .idx_i(idx_q), .sum_o(bus.out_rdest));

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = issuing;
  assign bus.out_idx   = idx_q;
  assign bus.out_last  = last_beat;
  assign fetch_stall   = issuing && !(last_beat && bus.out_ready);
`ifdef VGSEQ_ALIGN_CHECK_EN
  assign bus.out_illegal = illegal_q;
`else
  // Without the alignment check the flag register is never observed.
  logic unused_illegal;
  assign unused_illegal = illegal_q;
`endif

endmodule
